// File: rtl/counter_pkg.sv
/*------------------------------------------------------------------------------
 | counter_pkg                                                                 |
 | Shared mode/direction encodings for mode_counter and its prescaler.         |
 | Rev 1.0 - initial release                                                   |
 -----------------------------------------------------------------------------*/
`default_nettype none

package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/counter_prescaler.sv
/*------------------------------------------------------------------------------
 | counter_prescaler                                                           |
 | Divides enabled cycles: tick when divider==prescale (or at divider wrap).   |
 | Rev 1.0 - initial release                                                   |
 -----------------------------------------------------------------------------*/
`default_nettype none

module counter_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] r_div;

  // An all-ones divider also ticks so a prescale lowered below the divider
  // recovers at the natural wrap instead of rolling through zero first.
  assign tick = (r_div == prescale) | (&r_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (clr) begin
      r_div <= '0;
    end else if (en) begin
      r_div <= tick ? '0 : r_div + PRESCALE_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mode_counter.sv
/*------------------------------------------------------------------------------
 | mode_counter                                                                |
 | Up/down modulo counter with load, wrap/saturate, tc pulse and sticky ovf.   |
 | Optional prescaler enabled by macro MODE_COUNTER_PRESCALE_EN.               |
 | Rev 1.0 - initial release                                                   |
 -----------------------------------------------------------------------------*/
`default_nettype none

module mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1
`ifdef MODE_COUNTER_PRESCALE_EN
  ,
  parameter int PRESCALE_W = 4
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  clr_ovf,
`ifdef MODE_COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      value,
  output logic                  tc,
  output logic                  ovf
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_value;
  logic             r_tc;
  logic             r_ovf;
  logic             w_tick;
  logic             w_step;
  logic             w_boundary;
  logic [WIDTH-1:0] w_next;
  cnt_mode_e        w_mode;

`ifdef MODE_COUNTER_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (load),
    .prescale (prescale),
    .tick     (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  assign w_mode     = cnt_mode_e'(mode);
  assign w_step     = en & ~load & w_tick;
  assign w_boundary = w_step & ((up_dn == DIR_UP) ? (r_value == c_max) : (r_value == '0));

  always_comb begin
    w_next = r_value;
    if (load) begin
      w_next = (load_val > c_max) ? c_max : load_val;
    end else if (w_step) begin
      if (up_dn == DIR_UP) begin
        if (r_value == c_max) begin
          w_next = (w_mode == MODE_WRAP) ? '0 : c_max;
        end else begin
          w_next = r_value + c_one;
        end
      end else begin
        if (r_value == '0) begin
          w_next = (w_mode == MODE_WRAP) ? c_max : '0;
        end else begin
          w_next = r_value - c_one;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_value <= w_next;
      r_tc    <= w_boundary;
      // A boundary step in the same cycle as a clear keeps the flag set.
      if (w_boundary) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign value = r_value;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mode_counter.sv
/*------------------------------------------------------------------------------
 | tb_mode_counter                                                             |
 | Self-checking bench: MAX_VAL=9 and MAX_VAL=255 instances vs. a model.       |
 | Rev 1.0 - initial release                                                   |
 -----------------------------------------------------------------------------*/
`default_nettype none

module tb_mode_counter;

  localparam int PW = 4;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       en       = 1'b0;
  logic       up_dn    = 1'b1;
  logic       mode     = 1'b0;
  logic       load     = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       clr_ovf  = 1'b0;
`ifdef MODE_COUNTER_PRESCALE_EN
  logic [PW-1:0] prescale = '0;
`endif
  logic [7:0] value, value2;
  logic       tc, tc2, ovf, ovf2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state for each instance
  int m_v = 0, m_dv = 0, m2_v = 0, m2_dv = 0;
  bit m_tc = 0, m_ovf = 0, m2_tc = 0, m2_ovf = 0;

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(8), .MAX_VAL(9)
`ifdef MODE_COUNTER_PRESCALE_EN
    , .PRESCALE_W(PW)
`endif
  ) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf),
`ifdef MODE_COUNTER_PRESCALE_EN
    .prescale(prescale),
`endif
    .value(value), .tc(tc), .ovf(ovf)
  );

  mode_counter #(.WIDTH(8), .MAX_VAL(255)
`ifdef MODE_COUNTER_PRESCALE_EN
    , .PRESCALE_W(PW)
`endif
  ) dut255 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf),
`ifdef MODE_COUNTER_PRESCALE_EN
    .prescale(prescale),
`endif
    .value(value2), .tc(tc2), .ovf(ovf2)
  );

  // Behavioural model: modulo arithmetic for wrap, min/max for saturate.
  task automatic model_adv(input int mx, inout int v, inout bit t, inout bit o, inout int dv);
    bit tick;
    bit bnd;
    if (load) begin
      v  = (int'(load_val) > mx) ? mx : int'(load_val);
      t  = 0;
      dv = 0;
      if (clr_ovf) o = 0;
    end else if (!en) begin
      t = 0;
      if (clr_ovf) o = 0;
    end else begin
      tick = 1;
`ifdef MODE_COUNTER_PRESCALE_EN
      tick = (dv == int'(prescale)) || (dv == (1 << PW) - 1);
      dv   = tick ? 0 : dv + 1;
`endif
      if (!tick) begin
        t = 0;
        if (clr_ovf) o = 0;
      end else begin
        if (up_dn) begin
          bnd = (v == mx);
          v   = mode ? ((v + 1 > mx) ? mx : v + 1) : (v + 1) % (mx + 1);
        end else begin
          bnd = (v == 0);
          v   = mode ? ((v - 1 < 0) ? 0 : v - 1) : (v + mx) % (mx + 1);
        end
        t = bnd;
        o = bnd ? 1'b1 : (clr_ovf ? 1'b0 : o);
      end
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_dv = 0; m_tc = 0; m_ovf = 0;
    m2_v = 0; m2_dv = 0; m2_tc = 0; m2_ovf = 0;
  endtask

  task automatic step();
    model_adv(9, m_v, m_tc, m_ovf, m_dv);
    model_adv(255, m2_v, m2_tc, m2_ovf, m2_dv);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; en = 0;
    @(posedge clk); #1;
    model_reset();
    n_tests++; if (value !== 8'd0) begin n_fail++; $display("FAIL reset_value: got %0d expected 0", value); end
    n_tests++; if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %0b expected 0", tc); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
    reset = 0; en = 1; up_dn = 1; mode = 0;
    repeat (5) step();
    n_tests++; if (value !== 8'(m_v)) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected %0d", value, m_v); end
    @(negedge clk);
    reset = 1;
    #1;
    model_reset();
    n_tests++; if (value !== 8'd0 || tc !== 1'b0 || ovf !== 1'b0)
      begin n_fail++; $display("FAIL async_reset: got v=%0d tc=%0b ovf=%0b expected 0/0/0", value, tc, ovf); end
    @(negedge clk);
    reset = 0;
    step();
    n_tests++; if (value !== 8'd1) begin n_fail++; $display("FAIL restart_1: got %0d expected 1", value); end
    step();
    n_tests++; if (value !== 8'd2) begin n_fail++; $display("FAIL restart_2: got %0d expected 2", value); end
  endtask

  task automatic test_wrap_up();
    load = 1; load_val = 0; en = 0; clr_ovf = 1;
    step();
    load = 0; clr_ovf = 0; en = 1; up_dn = 1; mode = 0;
    for (int i = 0; i < 11; i++) begin
      step();
      n_tests++; if (value !== 8'(m_v) || tc !== m_tc || ovf !== m_ovf)
        begin n_fail++; $display("FAIL wrap_up[%0d]: got v=%0d tc=%0b ovf=%0b expected %0d/%0b/%0b", i, value, tc, ovf, m_v, m_tc, m_ovf); end
    end
    n_tests++; if (value !== 8'd1 || ovf !== 1'b1) begin n_fail++; $display("FAIL wrap_end: got v=%0d ovf=%0b expected 1/1", value, ovf); end
    en = 0; clr_ovf = 1;
    step();
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %0b expected 0", ovf); end
    clr_ovf = 0;
  endtask

  task automatic test_sat_down();
    load = 1; load_val = 2;
    step();
    load = 0; en = 1; mode = 1; up_dn = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++; if (value !== 8'(m_v) || tc !== m_tc || ovf !== m_ovf)
        begin n_fail++; $display("FAIL sat_down[%0d]: got v=%0d tc=%0b ovf=%0b expected %0d/%0b/%0b", i, value, tc, ovf, m_v, m_tc, m_ovf); end
    end
    n_tests++; if (value !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1)
      begin n_fail++; $display("FAIL sat_end: got v=%0d tc=%0b ovf=%0b expected 0/1/1", value, tc, ovf); end
  endtask

  task automatic test_load_clamp();
    bit ovf_before;
    ovf_before = m_ovf;
    load = 1; load_val = 8'd200; en = 1; up_dn = 1; mode = 1;
    step();
    n_tests++; if (value !== 8'd9 || tc !== 1'b0 || ovf !== ovf_before)
      begin n_fail++; $display("FAIL load_clamp: got v=%0d tc=%0b ovf=%0b expected 9/0/%0b", value, tc, ovf, ovf_before); end
    load = 0; clr_ovf = 1;
    step();
    n_tests++; if (value !== 8'd9 || tc !== 1'b1 || ovf !== 1'b1)
      begin n_fail++; $display("FAIL set_wins: got v=%0d tc=%0b ovf=%0b expected 9/1/1", value, tc, ovf); end
    clr_ovf = 0;
  endtask

  task automatic test_dir_change();
    load = 1; load_val = 9; mode = 0;
    step();
    load = 0; en = 1; up_dn = 0;
    step();
    n_tests++; if (value !== 8'd8 || tc !== 1'b0) begin n_fail++; $display("FAIL dir_change: got v=%0d tc=%0b expected 8/0", value, tc); end
    load = 1; load_val = 8'd255;
    step();
    load = 0; up_dn = 1;
    step();
    n_tests++; if (value2 !== 8'd0 || tc2 !== 1'b1) begin n_fail++; $display("FAIL wrap255: got v=%0d tc=%0b expected 0/1", value2, tc2); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      up_dn    = $urandom_range(0, 1);
      mode     = $urandom_range(0, 1);
      load     = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom_range(0, 255));
      clr_ovf  = ($urandom_range(0, 7) == 0);
`ifdef MODE_COUNTER_PRESCALE_EN
      if ($urandom_range(0, 19) == 0) prescale = PW'($urandom_range(0, (1 << PW) - 1));
`endif
      step();
      n_tests++; if (value !== 8'(m_v) || tc !== m_tc || ovf !== m_ovf)
        begin n_fail++; $display("FAIL rand9[%0d]: got v=%0d tc=%0b ovf=%0b expected %0d/%0b/%0b", i, value, tc, ovf, m_v, m_tc, m_ovf); end
      n_tests++; if (value2 !== 8'(m2_v) || tc2 !== m2_tc || ovf2 !== m2_ovf)
        begin n_fail++; $display("FAIL rand255[%0d]: got v=%0d tc=%0b ovf=%0b expected %0d/%0b/%0b", i, value2, tc2, ovf2, m2_v, m2_tc, m2_ovf); end
    end
    load = 0; clr_ovf = 0;
  endtask

`ifdef MODE_COUNTER_PRESCALE_EN
  task automatic test_prescale();
    int held;
    prescale = 2; load = 1; load_val = 0; en = 1;
    step();
    load = 0; up_dn = 1; mode = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_tests++; if (value !== 8'(m_v)) begin n_fail++; $display("FAIL prescale[%0d]: got %0d expected %0d", i, value, m_v); end
    end
    n_tests++; if (value !== 8'd2) begin n_fail++; $display("FAIL prescale_rate: got %0d expected 2", value); end
    step();
    held = m_v;
    en = 0;
    repeat (4) step();
    n_tests++; if (value !== 8'(held)) begin n_fail++; $display("FAIL prescale_hold: got %0d expected %0d", value, held); end
    en = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (value !== 8'(m_v)) begin n_fail++; $display("FAIL prescale_resume[%0d]: got %0d expected %0d", i, value, m_v); end
    end
    load = 1; load_val = 5;
    step();
    load = 0;
    repeat (2) step();
    n_tests++; if (value !== 8'd5) begin n_fail++; $display("FAIL prescale_load_wait: got %0d expected 5", value); end
    step();
    n_tests++; if (value !== 8'd6) begin n_fail++; $display("FAIL prescale_load_step: got %0d expected 6", value); end
    prescale = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load_clamp();
    test_dir_change();
`ifdef MODE_COUNTER_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
